// File: rtl/mul_issue_controller.sv
// Issue/handshake controller for an approximate multiplier: latches MUL requests, waits for completion, returns result.
// Optional watchdog enabled by defining MUL_ISSUE_TIMEOUT_EN (default build: no watchdog, timeout_err tied low).
module mul_issue_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GRACE_CYCLES   = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [6:0]  opcode_in,
  input  logic [6:0]  funct7_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] accuracy_control_in,
  input  logic        flush,
  input  logic        mul_unit_busy,
  input  logic [31:0] mul_output,
  output logic [6:0]  opcode,
  output logic [6:0]  funct7,
  output logic [2:0]  funct3,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic [31:0] accuracy_control,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        timeout_err
);

  localparam logic [6:0] MUL_OPCODE = 7'b0110011;
  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GCW = (GRACE_CYCLES < 1) ? 1 : $clog2(GRACE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_complete;
  logic             w_timeout;
  logic             r_seen_busy;
  logic [GCW-1:0]   r_grace_cnt;
  logic [WCW-1:0]   r_wait_cnt;
  logic [6:0]       r_opcode;
  logic [6:0]       r_funct7;
  logic [2:0]       r_funct3;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  logic [31:0]      r_acc;
  logic [31:0]      r_result;
  logic             r_result_valid;

  always_ff @(posedge CLK) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept = instr_valid && (opcode_in == MUL_OPCODE) && (funct7_in == MUL_FUNCT7) &&
               !funct3_in[2] && ((r_state == S_IDLE) || (r_state == S_DONE)) && !flush;
    // A unit that never raises busy is treated as single-cycle once the grace window expires.
    w_complete = (r_state == S_WAIT) && !mul_unit_busy &&
                 (r_seen_busy || (r_grace_cnt == GCW'(GRACE_CYCLES)));
`ifdef MUL_ISSUE_TIMEOUT_EN
    w_timeout = (r_state == S_WAIT) && !w_complete && (r_wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
`else
    w_timeout = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: w_state_next = w_accept ? S_ISSUE : S_IDLE;
      S_ISSUE:        w_state_next = S_WAIT;
      S_WAIT:         w_state_next = (w_complete || w_timeout) ? S_DONE : S_WAIT;
      default:        w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
    stall = w_accept || (r_state == S_ISSUE) || (r_state == S_WAIT);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_opcode <= '0; r_funct7 <= '0; r_funct3 <= '0;
      r_rs1 <= '0; r_rs2 <= '0; r_acc <= '0;
      r_result <= '0; r_result_valid <= 1'b0;
      r_seen_busy <= 1'b0; r_grace_cnt <= '0; r_wait_cnt <= '0;
    end else begin
      r_result_valid <= 1'b0;
      if (flush) begin
        r_opcode <= '0; r_funct7 <= '0; r_funct3 <= '0;
        r_rs1 <= '0; r_rs2 <= '0; r_acc <= '0;
        r_seen_busy <= 1'b0; r_grace_cnt <= '0; r_wait_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_accept) begin
              r_opcode <= opcode_in; r_funct7 <= funct7_in; r_funct3 <= funct3_in;
              r_rs1 <= rs1_in; r_rs2 <= rs2_in; r_acc <= accuracy_control_in;
            end else begin
              r_opcode <= '0; r_funct7 <= '0; r_funct3 <= '0;
              r_rs1 <= '0; r_rs2 <= '0; r_acc <= '0;
            end
          end
          S_ISSUE: begin
            r_seen_busy <= 1'b0; r_grace_cnt <= '0; r_wait_cnt <= '0;
          end
          S_WAIT: begin
            if (mul_unit_busy) r_seen_busy <= 1'b1;
            if (w_complete) begin
              r_result <= mul_output;
              r_result_valid <= 1'b1;
            end else if (w_timeout) begin
              r_result <= '0;
              r_result_valid <= 1'b1;
            end else begin
              if (r_grace_cnt != GCW'(GRACE_CYCLES)) r_grace_cnt <= r_grace_cnt + GCW'(1);
              if (r_wait_cnt != WCW'(TIMEOUT_CYCLES)) r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MUL_ISSUE_TIMEOUT_EN
  logic r_timeout_err;
  always_ff @(posedge CLK) begin
    if (reset || flush) r_timeout_err <= 1'b0;
    else                r_timeout_err <= w_timeout;
  end
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign opcode           = r_opcode;
  assign funct7           = r_funct7;
  assign funct3           = r_funct3;
  assign rs1              = r_rs1;
  assign rs2              = r_rs2;
  assign accuracy_control = r_acc;
  assign result           = r_result;
  assign result_valid     = r_result_valid;

endmodule

// File: tb/tb_mul_issue_controller.sv
// Scoreboard bench for mul_issue_controller: expected results queued at accept, checked on each result_valid.
module tb_mul_issue_controller;

  logic        CLK = 1'b0;
  logic        reset, instr_valid, flush, mul_unit_busy;
  logic [6:0]  opcode_in, funct7_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs1_in, rs2_in, accuracy_control_in, mul_output;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, accuracy_control, result;
  logic        stall, result_valid, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_expected = 0;
  int n_pulses   = 0;
  logic [31:0] exp_q[$];
  logic        exp_to_q[$];

  always #5 CLK = ~CLK;

  mul_issue_controller dut (
    .CLK(CLK), .reset(reset), .instr_valid(instr_valid),
    .opcode_in(opcode_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .accuracy_control_in(accuracy_control_in),
    .flush(flush), .mul_unit_busy(mul_unit_busy), .mul_output(mul_output),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .accuracy_control(accuracy_control),
    .stall(stall), .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!reset && result_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        logic        t;
        e = exp_q.pop_front();
        t = exp_to_q.pop_front();
        check("result", result, e);
        check("timeout_err", {31'd0, timeout_err}, {31'd0, t});
        $display("writeback: result=%0d timeout_err=%0b (expected %0d/%0b)", result, timeout_err, e, t);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc);
    instr_valid = 1'b1; opcode_in = op; funct7_in = f7; funct3_in = f3;
    rs1_in = a; rs2_in = b; accuracy_control_in = acc;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                        input logic [31:0] exp, input logic to);
    set_instr(7'b0110011, 7'b0000001, 3'b000, a, b, acc);
    #1;
    check("accept_stall", {31'd0, stall}, 32'd1);
    exp_q.push_back(exp);
    exp_to_q.push_back(to);
    n_expected++;
    tick();
    instr_valid = 1'b0;
    check("issue_stall", {31'd0, stall}, 32'd1);
    check("req_opcode", {25'd0, opcode}, 32'h33);
    check("req_funct7", {25'd0, funct7}, 32'd1);
    check("req_rs1", rs1, a);
    check("req_rs2", rs2, b);
    check("req_acc", accuracy_control, acc);
  endtask

  // Called in the ISSUE cycle; busy stays high for busy_k cycles, then the product appears.
  task automatic finish_op(input int busy_k, input logic [31:0] prod, input int exp_lat,
                           input logic [31:0] a);
    int lat = 0;
    while (lat < 100) begin
      mul_unit_busy = (lat < busy_k);
      mul_output    = (lat < busy_k) ? 32'hDEADBEEF : prod;
      tick();
      lat++;
      if (result_valid) break;
      check("wait_stall", {31'd0, stall}, 32'd1);
      check("wait_hold_rs1", rs1, a);
    end
    mul_unit_busy = 1'b0;
    if (!result_valid) check("completion_timeout", 32'd0, 32'd1);
    else begin
      check("latency", lat, exp_lat);
      check("done_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic idle_check(input string tag);
    tick();
    check({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_rs1"}, rs1, 32'd0);
    check({tag, "_opcode"}, {25'd0, opcode}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] to_exp;
    logic        to_flag;
    int          to_lat;
    reset = 1'b1; instr_valid = 1'b0; flush = 1'b0; mul_unit_busy = 1'b0;
    opcode_in = '0; funct7_in = '0; funct3_in = '0;
    rs1_in = '0; rs2_in = '0; accuracy_control_in = '0; mul_output = '0;
    repeat (3) tick();
    check("rst_opcode", {25'd0, opcode}, 32'd0);
    check("rst_rs1", rs1, 32'd0);
    check("rst_acc", accuracy_control, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_to", {31'd0, timeout_err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    tick();

    // Multi-cycle multiply with busy handshake
    accept(32'd500, 32'd55, 32'h7F9, 32'd27500, 1'b0);
    finish_op(4, 32'd27500, 5, 32'd500);
    idle_check("after_op1");

    // Busy never rises: grace-window completion
    accept(32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    finish_op(0, 32'd42, 4, 32'd7);
    idle_check("after_grace");

    // DIV and non-OP opcodes are ignored
    set_instr(7'b0110011, 7'b0000001, 3'b100, 32'd9, 32'd9, 32'd9);
    #1 check("div_stall", {31'd0, stall}, 32'd0);
    tick();
    check("div_rs1", rs1, 32'd0);
    check("div_state_stall", {31'd0, stall}, 32'd0);
    set_instr(7'b0010011, 7'b0000001, 3'b000, 32'd9, 32'd9, 32'd9);
    #1 check("opimm_stall", {31'd0, stall}, 32'd0);
    tick();
    check("opimm_opcode", {25'd0, opcode}, 32'd0);
    instr_valid = 1'b0;

    // Flush during WAIT with busy high
    accept(32'd11, 32'd12, 32'd0, 32'd132, 1'b0);
    mul_unit_busy = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_to_q.pop_back());
    n_expected--;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_rs1", rs1, 32'd0);
    check("flush_rv", {31'd0, result_valid}, 32'd0);
    check("flush_result_kept", result, 32'd42);
    mul_unit_busy = 1'b0;
    idle_check("after_flush");
    accept(32'd13, 32'd3, 32'd0, 32'd39, 1'b0);
    finish_op(4, 32'd39, 5, 32'd13);
    idle_check("after_flush_op");

    // Back-to-back: second accept lands in the DONE cycle of the first
    accept(32'd6000, 32'd7000, 32'd0, 32'd42000000, 1'b0);
    finish_op(3, 32'd42000000, 4, 32'd6000);
    accept(32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    finish_op(0, 32'd12, 4, 32'd3);
    idle_check("after_b2b");

    // Reset mid-operation abandons it
    accept(32'd5, 32'd5, 32'd0, 32'd25, 1'b0);
    mul_unit_busy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_to_q.pop_back());
    n_expected--;
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_rv", {31'd0, result_valid}, 32'd0);
    mul_unit_busy = 1'b0;
    idle_check("after_rstmid");

    // Long busy: watchdog fires after 64 WAIT cycles if enabled, else completion on busy fall
`ifdef MUL_ISSUE_TIMEOUT_EN
    to_exp = 32'd0; to_flag = 1'b1; to_lat = 65;
`else
    to_exp = 32'd20000; to_flag = 1'b0; to_lat = 71;
`endif
    accept(32'd100, 32'd200, 32'd0, to_exp, to_flag);
    finish_op(70, 32'd20000, to_lat, 32'd100);
    idle_check("after_long");

    tick();
    check("queue_empty", exp_q.size(), 32'd0);
    check("pulse_count", n_pulses, n_expected);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue_controller.md
MUL_ISSUE_CONTROLLER -- requirements
Module: mul_issue_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum WAIT-state cycles before the watchdog fires (only with MUL_ISSUE_TIMEOUT_EN).
REQ-002 Parameter GRACE_CYCLES, default 2, SHALL set the WAIT cycles allowed for busy to rise before single-cycle completion is assumed.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr_valid  in  1  decode stage presents an instruction.
REQ-006 opcode_in / funct7_in / funct3_in  in  7/7/3  decoded instruction fields.
REQ-007 rs1_in, rs2_in, accuracy_control_in  in  32 each  operands and approximation control.
REQ-008 flush  in  1  pipeline flush; aborts any in-flight operation.
REQ-009 mul_unit_busy  in  1  busy flag from the multiplier unit.
REQ-010 mul_output  in  32  multiplier result.
REQ-011 opcode, funct7, funct3, rs1, rs2, accuracy_control  out  7/7/3/32/32/32  registered request to the multiplier unit.
REQ-012 stall  out  1  holds upstream pipeline stages.
REQ-013 result  out  32  captured product, registered.
REQ-014 result_valid  out  1  one-cycle write-back strobe.
REQ-015 timeout_err  out  1  watchdog indication (MUL_ISSUE_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-016 Accept condition SHALL be: instr_valid && opcode_in==0110011 && funct7_in==0000001 && funct3_in[2]==0, in state IDLE or DONE, with flush low; other instructions are ignored.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-018 On accept, all inputs SHALL be latched into the request outputs and the FSM SHALL move to ISSUE.
REQ-019 ISSUE SHALL last exactly one cycle, clear seen_busy and the grace/wait counters, then enter WAIT.
REQ-020 In WAIT, mul_unit_busy==1 SHALL set seen_busy.
REQ-021 In WAIT, completion SHALL occur when mul_unit_busy==0 and (seen_busy==1 or grace counter==GRACE_CYCLES); result<=mul_output, FSM->DONE.
REQ-022 In DONE, result_valid SHALL be 1 for exactly that cycle; request outputs SHALL clear to zero unless a new accept occurs, in which case FSM->ISSUE (back-to-back).
REQ-023 stall SHALL equal accept_now OR state in {ISSUE, WAIT} (combinational); low in DONE and in idle IDLE.
REQ-024 Request outputs SHALL remain stable from ISSUE through WAIT.
REQ-025 flush SHALL take priority over accept and completion: next state IDLE, request outputs zeroed, result_valid not asserted, result unchanged.
REQ-026 Wait counter SHALL saturate, never wrap.

Reset
REQ-027 With reset high at a clock edge: state IDLE; opcode, funct7, funct3, rs1, rs2, accuracy_control, result = 0; result_valid, timeout_err, seen_busy = 0; counters = 0.
REQ-028 Reset mid-operation SHALL abandon the operation with no result_valid; stall SHALL be low in the following cycle unless an accept occurs.

Configuration
REQ-029 Macro MUL_ISSUE_TIMEOUT_EN defined: when the WAIT cycle count reaches TIMEOUT_CYCLES without completion, result<=0, timeout_err=1 and result_valid=1 for one cycle (DONE), and the FSM returns to IDLE.
REQ-030 Macro undefined: no watchdog; WAIT persists until completion, flush, or reset; timeout_err tied to 0.

Verification
REQ-031 Accept MUL, rs1=500, rs2=55, accuracy_control=0x7F9; busy high 4 cycles then low with mul_output=27500 -> result=27500, one result_valid pulse, stall high from accept until DONE.
REQ-032 Accept MUL; busy never rises, mul_output=42 -> completion after GRACE_CYCLES=2 WAIT cycles, result=42.
REQ-033 funct7_in=0000001, funct3_in=100 (DIV) -> not accepted; stall=0, request outputs stay 0.
REQ-034 flush asserted during WAIT with busy high -> IDLE next cycle, no result_valid, outputs zeroed; a following accept completes normally.
REQ-035 Accept in DONE cycle of a prior op (6000x7000, then 3x4) -> two result_valid pulses, results 42000000 then 12, no idle cycle between them.
REQ-036 With MUL_ISSUE_TIMEOUT_EN, busy held high 70 cycles -> after 64 WAIT cycles: timeout_err=1, result=0, result_valid=1; without the macro, completion occurs on busy fall.
